// File: rtl/idma_2d_pkg.sv
// Shared types for the 2D iDMA midend: FSM state encoding and the 2D
// request layout as the frontend presents it in the default configuration.
package idma_2d_pkg;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefRepWidth  = 32;

  // IDLE waits for a 2D job, ISSUE emits one 1D burst per row.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // One 2D transfer as handed over by the register frontend.
  typedef struct packed {
    logic [DefAddrWidth-1:0] src_addr;
    logic [DefAddrWidth-1:0] dst_addr;
    logic [DefAddrWidth-1:0] length;
    logic [DefAddrWidth-1:0] src_stride;
    logic [DefAddrWidth-1:0] dst_stride;
    logic [DefRepWidth-1:0]  num_reps;
    logic                    opt;
  } req_t;

endpackage

// File: rtl/idma_2d_comp_tracker.sv
// Completion tracker: remembers the row count of every accepted 2D job in a
// small FIFO, counts backend row completions and emits one pulse per job.
module idma_2d_comp_tracker #(
  parameter int unsigned RepWidth = 32,
  parameter int unsigned Depth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [RepWidth-1:0] push_reps_i,
  input  logic                be_complete_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                trans_complete_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [RepWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [RepWidth-1:0] done_cnt_q, done_inc;
  logic                trans_complete_q;
  logic                do_push, do_pop;

  assign full_o   = (count_q == CntW'(Depth));
  assign empty_o  = (count_q == '0);
  assign done_inc = done_cnt_q + RepWidth'(1);

  // A completion while empty is a protocol error and is dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = be_complete_i && !empty_o && (done_inc == mem_q[rd_ptr_q]);

  assign trans_complete_o = trans_complete_q;

  // FIFO storage and pointers; push and pop may happen in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_reps_i;
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Row completion counter for the job at the FIFO head, plus the job pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_cnt_q       <= '0;
      trans_complete_q <= 1'b0;
    end else begin
      trans_complete_q <= do_pop;
      if (be_complete_i && !empty_o) begin
        done_cnt_q <= do_pop ? '0 : done_inc;
      end
    end
  end

  // Backend must never report a completion with no job outstanding.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(be_complete_i && empty_o));

endmodule

// File: rtl/idma_2d_midend.sv
// 2D iDMA midend: splits one 2D job into num_reps 1D bursts and folds the
// per-row backend completions back into a single completion per job.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready, and once valid is high it stays high
// with stable payload until that transfer happens.
module idma_2d_midend
  import idma_2d_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned RepWidth      = 32,
  parameter int unsigned CompFifoDepth = 4,
  parameter type         opt_t         = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AddrWidth-1:0]      src_addr_i,
  input  logic [AddrWidth-1:0]      dst_addr_i,
  input  logic [AddrWidth-1:0]      length_i,
  input  logic [AddrWidth-1:0]      src_stride_i,
  input  logic [AddrWidth-1:0]      dst_stride_i,
  input  logic [RepWidth-1:0]       num_reps_i,
  input  logic [$bits(opt_t)-1:0]   opt_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [AddrWidth-1:0]      src_addr_o,
  output logic [AddrWidth-1:0]      dst_addr_o,
  output logic [AddrWidth-1:0]      length_o,
  output logic [$bits(opt_t)-1:0]   opt_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  input  logic                      be_trans_complete_i,
  output logic                      trans_complete_o,
  output logic                      busy_o,
  output logic                      dbg_state_o
);

  state_e                    state_q, state_d;
  logic [AddrWidth-1:0]      cur_src_q, cur_dst_q, length_q;
  logic [AddrWidth-1:0]      src_stride_q, dst_stride_q;
  logic [$bits(opt_t)-1:0]   opt_q;
  logic [RepWidth-1:0]       rep_cnt_q, last_rep_q;
  logic [RepWidth-1:0]       eff_reps_in;
  logic                      accept, issue_hs;
  logic                      comp_full, comp_empty;

  // Zero repetitions means a plain 1D transfer.
  assign eff_reps_in = (num_reps_i == '0) ? RepWidth'(1) : num_reps_i;
  assign accept      = valid_i && ready_o;
  assign issue_hs    = valid_o && ready_i;

  assign src_addr_o  = cur_src_q;
  assign dst_addr_o  = cur_dst_q;
  assign length_o    = length_q;
  assign opt_o       = opt_q;
  assign busy_o      = (state_q == ISSUE) || !comp_empty;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake outputs; new jobs only when a FIFO slot is free.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = !comp_full;
        if (valid_i && !comp_full) state_d = ISSUE;
      end
      ISSUE: begin
        valid_o = 1'b1;
        if (ready_i && (rep_cnt_q == last_rep_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job latch and per-row address stepping; sums wrap modulo 2^AddrWidth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      length_q     <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      opt_q        <= '0;
      rep_cnt_q    <= '0;
      last_rep_q   <= '0;
    end else if (accept) begin
      cur_src_q    <= src_addr_i;
      cur_dst_q    <= dst_addr_i;
      length_q     <= length_i;
      src_stride_q <= src_stride_i;
      dst_stride_q <= dst_stride_i;
      opt_q        <= opt_i;
      rep_cnt_q    <= '0;
      last_rep_q   <= eff_reps_in - RepWidth'(1);
    end else if (issue_hs) begin
      cur_src_q <= cur_src_q + src_stride_q;
      cur_dst_q <= cur_dst_q + dst_stride_q;
      rep_cnt_q <= rep_cnt_q + RepWidth'(1);
    end
  end

  idma_2d_comp_tracker #(
    .RepWidth (RepWidth),
    .Depth    (CompFifoDepth)
  ) i_comp_tracker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .push_i           (accept),
    .push_reps_i      (eff_reps_in),
    .be_complete_i    (be_trans_complete_i),
    .full_o           (comp_full),
    .empty_o          (comp_empty),
    .trans_complete_o (trans_complete_o)
  );

endmodule

// File: tb/tb_idma_2d_midend.sv
// Bench for idma_2d_midend: directed scenarios plus random traffic, checked
// every cycle against a job-level model (row addresses as base + i*stride,
// a queue of outstanding job row counts).
module tb_idma_2d_midend;

  localparam int DEPTH = 4;
  localparam int BW    = 3 * 64 + 1;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] len;
    logic [63:0] ss;
    logic [63:0] ds;
    logic [31:0] reps;
    logic        opt;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] src_addr_i = '0, dst_addr_i = '0, length_i = '0;
  logic [63:0] src_stride_i = '0, dst_stride_i = '0;
  logic [31:0] num_reps_i = '0;
  logic        opt_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0, be_c = 1'b0;
  logic        ready_o, valid_o, trans_complete_o, busy_o, dbg_state_o;
  logic [63:0] src_addr_o, dst_addr_o, length_o;
  logic        opt_o;

  // scoreboard state
  job_t           pend_q[$];
  logic [BW-1:0]  exp_q[$];
  int unsigned    jobs_q[$];
  int unsigned    done_rows = 0;
  int             open_rows = 0;
  logic           exp_pulse = 1'b0;
  int             vld_pct = 100, rdy_pct = 100, cmp_pct = 100;
  int             n_cmp = 0, n_err = 0;

  idma_2d_midend dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .src_addr_i          (src_addr_i),
    .dst_addr_i          (dst_addr_i),
    .length_i            (length_i),
    .src_stride_i        (src_stride_i),
    .dst_stride_i        (dst_stride_i),
    .num_reps_i          (num_reps_i),
    .opt_i               (opt_i),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .src_addr_o          (src_addr_o),
    .dst_addr_o          (dst_addr_o),
    .length_o            (length_o),
    .opt_o               (opt_o),
    .valid_o             (valid_o),
    .ready_i             (ready_i),
    .be_trans_complete_i (be_c),
    .trans_complete_o    (trans_complete_o),
    .busy_o              (busy_o),
    .dbg_state_o         (dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic job_t mk_job(input logic [63:0] src, input logic [63:0] dst,
                                  input logic [63:0] len, input logic [63:0] ss,
                                  input logic [63:0] ds, input logic [31:0] reps,
                                  input logic opt);
    job_t j;
    j.src = src; j.dst = dst; j.len = len; j.ss = ss; j.ds = ds;
    j.reps = reps; j.opt = opt;
    return j;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Expected rows of a job: row i reads src + i*ss and writes dst + i*ds.
  task automatic expand(input job_t j);
    int unsigned eff;
    logic [63:0] s, d, idx;
    eff = (j.reps == 0) ? 1 : j.reps;
    for (int unsigned i = 0; i < eff; i++) begin
      idx = 64'(i);
      s = j.src + idx * j.ss;
      d = j.dst + idx * j.ds;
      exp_q.push_back({j.opt, j.len, d, s});
    end
    jobs_q.push_back(eff);
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic run_cycle();
    logic          e_valid, e_ready, e_busy;
    logic [BW-1:0] b;
    job_t          j;
    @(negedge clk);
    e_valid = (exp_q.size() > 0);
    e_ready = !e_valid && (jobs_q.size() < DEPTH);
    e_busy  = e_valid || (jobs_q.size() > 0);
    check("valid_o", valid_o, e_valid);
    check("ready_o", ready_o, e_ready);
    check("busy_o", busy_o, e_busy);
    check("trans_complete_o", trans_complete_o, exp_pulse);
    if (e_valid) begin
      b = exp_q[0];
      check("src_addr_o", src_addr_o, b[63:0]);
      check("dst_addr_o", dst_addr_o, b[127:64]);
      check("length_o", length_o, b[191:128]);
      check("opt_o", 64'(opt_o), 64'(b[192]));
    end
    valid_i = (pend_q.size() > 0) && ($urandom_range(99) < vld_pct);
    if (pend_q.size() > 0) begin
      j = pend_q[0];
      src_addr_i = j.src; dst_addr_i = j.dst; length_i = j.len;
      src_stride_i = j.ss; dst_stride_i = j.ds; num_reps_i = j.reps; opt_i = j.opt;
    end else begin
      src_addr_i = r64(); dst_addr_i = r64(); length_i = r64();
      src_stride_i = r64(); dst_stride_i = r64(); num_reps_i = $urandom;
      opt_i = 1'($urandom_range(1));
    end
    ready_i = ($urandom_range(99) < rdy_pct);
    be_c    = (open_rows > 0) && ($urandom_range(99) < cmp_pct);
    exp_pulse = 1'b0;
    if (be_c) begin
      open_rows--;
      done_rows++;
      if (done_rows == jobs_q[0]) begin
        void'(jobs_q.pop_front());
        done_rows = 0;
        exp_pulse = 1'b1;
      end
    end
    if (e_valid && ready_i) begin
      void'(exp_q.pop_front());
      open_rows++;
    end
    if (valid_i && e_ready) begin
      j = pend_q.pop_front();
      expand(j);
    end
  endtask

  function automatic logic idle_model();
    return (pend_q.size() == 0) && (exp_q.size() == 0) && (jobs_q.size() == 0) && !exp_pulse;
  endfunction

  // Run with full throughput until the model has nothing in flight.
  task automatic drain(input string tag, input int limit);
    int n;
    vld_pct = 100; rdy_pct = 100; cmp_pct = 100;
    n = 0;
    while (!idle_model() && n < limit) begin
      run_cycle();
      n++;
    end
    check(tag, 64'(idle_model()), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_tc"}, trans_complete_o, 1'b0);
    check({tag, "_src"}, src_addr_o, 64'h0);
    check({tag, "_dst"}, dst_addr_o, 64'h0);
    check({tag, "_len"}, length_o, 64'h0);
    check({tag, "_opt"}, 64'(opt_o), 64'h0);
    check({tag, "_state"}, 64'(dbg_state_o), 64'h0);
  endtask

  initial begin
    int n;
    // reset
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single 3-row job, full throughput
    pend_q.push_back(mk_job(64'h1000, 64'h8000, 64'd64, 64'h100, 64'h40, 32'd3, 1'b1));
    drain("single_job", 50);

    // backpressure: first burst stalled for 5 cycles
    pend_q.push_back(mk_job(64'h2000, 64'h9000, 64'd32, 64'h20, 64'h10, 32'd2, 1'b0));
    rdy_pct = 0; cmp_pct = 100;
    for (int i = 0; i < 6; i++) run_cycle();
    drain("backpressure", 50);

    // zero reps behaves as one 1D burst
    pend_q.push_back(mk_job(64'h3000, 64'hA000, 64'd16, 64'h55, 64'h66, 32'd0, 1'b1));
    drain("zero_reps", 50);

    // address wrap-around
    pend_q.push_back(mk_job(64'hFFFF_FFFF_FFFF_FF00, 64'h100, 64'd8, 64'h100, 64'h8, 32'd2, 1'b0));
    drain("wrap", 50);

    // four outstanding jobs fill the completion FIFO; fifth must wait
    for (int i = 0; i < 5; i++)
      pend_q.push_back(mk_job(64'h10000 * 64'(i + 1), 64'h20000 * 64'(i + 1), 64'd128,
                              64'h80, 64'h100, 32'd3, 1'(i)));
    rdy_pct = 100; cmp_pct = 0;
    for (int i = 0; i < 24; i++) run_cycle();
    drain("pipelining", 200);

    // asynchronous reset in the middle of a 4-row job
    pend_q.push_back(mk_job(64'h4000, 64'hB000, 64'd64, 64'h40, 64'h40, 32'd4, 1'b1));
    rdy_pct = 100; cmp_pct = 0;
    n = 0;
    while (open_rows < 1 && n < 20) begin
      run_cycle();
      n++;
    end
    check("reset_setup", 64'(open_rows), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pend_q.delete(); exp_q.delete(); jobs_q.delete();
    done_rows = 0; open_rows = 0; exp_pulse = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; be_c = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    pend_q.push_back(mk_job(64'h5000, 64'hC000, 64'd32, 64'h10, 64'h20, 32'd3, 1'b0));
    drain("after_reset", 50);

    // random traffic
    vld_pct = 70; rdy_pct = 60; cmp_pct = 50;
    for (int i = 0; i < 600; i++) begin
      if (pend_q.size() < 2 && $urandom_range(3) == 0)
        pend_q.push_back(mk_job(r64(), r64(), r64(), r64(), r64(),
                                32'($urandom_range(5)), 1'($urandom_range(1))));
      if (i % 150 == 0) begin
        rdy_pct = $urandom_range(20, 100);
        cmp_pct = $urandom_range(10, 100);
      end
      run_cycle();
    end
    drain("random_drain", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
